// File: rtl/present_key_stream.sv
// PRESENT key-schedule engine (80/128-bit master key) streaming one 64-bit round key per handshake.
// Define PRESENT_KS_REVERSE_EN to add the precompute-then-stream-backwards mode used for decryption.
module present_key_stream #(
  parameter int KEY_W  = 80,
  parameter int NUM_RK = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             rev_i,
  input  logic [KEY_W-1:0] key_in_i,
  output logic [63:0]      rk_o,
  output logic [5:0]       rk_idx_o,
  output logic             rk_last_o,
  output logic             rk_valid_o,
  input  logic             rk_ready_i,
  output logic             busy_o
);

  localparam int         XOR_LSB   = (KEY_W == 128) ? 62 : 15;
  localparam logic [5:0] FIRST_IDX = 6'd1;
  localparam logic [5:0] LAST_IDX  = 6'(NUM_RK);
`ifdef PRESENT_KS_REVERSE_EN
  localparam logic       REV_EN    = 1'b1;
  localparam logic [4:0] PRE_LAST  = 5'(NUM_RK - 1);
`else
  localparam logic       REV_EN    = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef PRESENT_KS_REVERSE_EN
    S_PRE  = 2'd2,
`endif
    S_EMIT = 2'd1
  } state_e;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [5:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             rev_sel_s;
  logic [5:0]       end_idx_q_s, end_idx_d_s;
`ifdef PRESENT_KS_REVERSE_EN
  logic             rev_q, rev_d;
  logic [4:0]       cnt_q, cnt_d;
`endif

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;
      4'h1: sbox = 4'h5;
      4'h2: sbox = 4'h6;
      4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;
      4'h5: sbox = 4'h0;
      4'h6: sbox = 4'hA;
      4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;
      4'h9: sbox = 4'hE;
      4'hA: sbox = 4'hF;
      4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;
      4'hD: sbox = 4'h7;
      4'hE: sbox = 4'h1;
      default: sbox = 4'h2;
    endcase
  endfunction

  // Rotate left 61, substitute the top nibble(s), fold in the round counter.
  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k, input logic [4:0] rc);
    logic [KEY_W-1:0] t;
    t = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    t[KEY_W-1 -: 4] = sbox(t[KEY_W-1 -: 4]);
    t[KEY_W-5 -: 4] = (KEY_W == 128) ? sbox(t[KEY_W-5 -: 4]) : t[KEY_W-5 -: 4];
    t[XOR_LSB +: 5] = t[XOR_LSB +: 5] ^ rc;
    return t;
  endfunction

`ifdef PRESENT_KS_REVERSE_EN
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;
      4'h1: sbox_inv = 4'hE;
      4'h2: sbox_inv = 4'hF;
      4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;
      4'h5: sbox_inv = 4'h1;
      4'h6: sbox_inv = 4'h2;
      4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;
      4'h9: sbox_inv = 4'h4;
      4'hA: sbox_inv = 4'h6;
      4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;
      4'hD: sbox_inv = 4'h7;
      4'hE: sbox_inv = 4'h9;
      default: sbox_inv = 4'hA;
    endcase
  endfunction

  function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k, input logic [4:0] rc);
    logic [KEY_W-1:0] t;
    t = k;
    t[XOR_LSB +: 5] = t[XOR_LSB +: 5] ^ rc;
    t[KEY_W-1 -: 4] = sbox_inv(t[KEY_W-1 -: 4]);
    t[KEY_W-5 -: 4] = (KEY_W == 128) ? sbox_inv(t[KEY_W-5 -: 4]) : t[KEY_W-5 -: 4];
    return {t[60:0], t[KEY_W-1:61]};
  endfunction
`endif

  assign rev_sel_s = rev_i & REV_EN;

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
`ifdef PRESENT_KS_REVERSE_EN
    rev_d       = rev_q;
    cnt_d       = cnt_q;
    end_idx_q_s = rev_q ? FIRST_IDX : LAST_IDX;
`else
    end_idx_q_s = LAST_IDX;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          key_d = key_in_i;
          if (rev_sel_s) begin
`ifdef PRESENT_KS_REVERSE_EN
            rev_d   = 1'b1;
            cnt_d   = 5'd1;
            state_d = S_PRE;
`else
            idx_d   = FIRST_IDX;
            state_d = S_EMIT;
`endif
          end else begin
`ifdef PRESENT_KS_REVERSE_EN
            rev_d   = 1'b0;
`endif
            idx_d   = FIRST_IDX;
            state_d = S_EMIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef PRESENT_KS_REVERSE_EN
      S_PRE: begin
        key_d = key_fwd(key_q, cnt_q);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == PRE_LAST) begin
          idx_d   = LAST_IDX;
          state_d = S_EMIT;
        end else begin
          state_d = S_PRE;
        end
      end
`endif
      S_EMIT: begin
        if (rk_ready_i) begin
          if (idx_q == end_idx_q_s) begin
            state_d = S_IDLE;
`ifdef PRESENT_KS_REVERSE_EN
          end else if (rev_q) begin
            key_d = key_inv(key_q, 5'(idx_q - FIRST_IDX));
            idx_d = idx_q - FIRST_IDX;
`endif
          end else begin
            key_d = key_fwd(key_q, idx_q[4:0]);
            idx_d = idx_q + FIRST_IDX;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef PRESENT_KS_REVERSE_EN
    end_idx_d_s = rev_d ? FIRST_IDX : LAST_IDX;
`else
    end_idx_d_s = LAST_IDX;
`endif
    valid_d = (state_d == S_EMIT);
    busy_d  = (state_d != S_IDLE);
    last_d  = valid_d && (idx_d == end_idx_d_s);
  end

  // State, key and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      key_q   <= {KEY_W{1'b0}};
      idx_q   <= 6'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PRESENT_KS_REVERSE_EN
      rev_q   <= 1'b0;
      cnt_q   <= 5'd0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
`ifdef PRESENT_KS_REVERSE_EN
      rev_q   <= rev_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign rk_o       = key_q[KEY_W-1 -: 64];
  assign rk_idx_o   = idx_q;
  assign rk_valid_o = valid_q;
  assign rk_last_o  = last_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_present_key_stream.sv
// Bench for present_key_stream: an 80-bit and a 128-bit instance share one stimulus stream and are
// checked every cycle against a schedule model plus directed literal expectations.
module tb_present_key_stream;
  localparam int NUM_RK = 32;
`ifdef PRESENT_KS_REVERSE_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif

  logic clk, rst, start, rev, ready;
  logic [79:0]  k80;
  logic [127:0] k128;
  logic [63:0]  rk80, rk128;
  logic [5:0]   idx80, idx128;
  logic last80, last128, valid80, valid128, busy80, busy128;

  int checks = 0;
  int errors = 0;

  present_key_stream #(.KEY_W(80), .NUM_RK(NUM_RK)) dut80 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .rev_i(rev), .key_in_i(k80),
    .rk_o(rk80), .rk_idx_o(idx80), .rk_last_o(last80), .rk_valid_o(valid80),
    .rk_ready_i(ready), .busy_o(busy80)
  );

  present_key_stream #(.KEY_W(128), .NUM_RK(NUM_RK)) dut128 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .rev_i(rev), .key_in_i(k128),
    .rk_o(rk128), .rk_idx_o(idx128), .rk_last_o(last128), .rk_valid_o(valid128),
    .rk_ready_i(ready), .busy_o(busy128)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Golden round keys for the run in progress, indexed by round number.
  logic [63:0] gold80  [1:NUM_RK];
  logic [63:0] gold128 [1:NUM_RK];

  function automatic logic [3:0] m_sbox(input logic [3:0] x);
    logic [63:0] tab;
    int p;
    tab = 64'hC56B90AD3EF84712;
    p = 15 - int'(x);
    return tab[p*4 +: 4];
  endfunction

  task automatic gen_gold(input logic [79:0] ka, input logic [127:0] kb);
    logic [79:0]  a;
    logic [127:0] b;
    a = ka;
    b = kb;
    for (int r = 1; r <= NUM_RK; r++) begin
      gold80[r]  = a[79:16];
      gold128[r] = b[127:64];
      a = (a << 61) | (a >> 19);
      a[79:76] = m_sbox(a[79:76]);
      a[19:15] = a[19:15] ^ 5'(r);
      b = (b << 61) | (b >> 67);
      b[127:124] = m_sbox(b[127:124]);
      b[123:120] = m_sbox(b[123:120]);
      b[66:62] = b[66:62] ^ 5'(r);
    end
  endtask

  // Protocol model: busy/valid/index sequence derived from accepted starts and handshakes.
  bit m_busy = 1'b0;
  bit m_rev = 1'b0;
  bit m_after_rst = 1'b1;
  bit m_valid;
  int m_exp = 0;
  int m_end = 0;
  int m_pre = 0;

  always @(negedge clk) begin
    m_valid = m_busy && (m_pre == 0);
    if (m_after_rst) begin
      chk("rst_rk80", rk80, 64'd0);
      chk("rst_rk128", rk128, 64'd0);
      chk("rst_idx80", 64'(idx80), 64'd0);
    end
    chk("busy80", 64'(busy80), 64'(m_busy));
    chk("busy128", 64'(busy128), 64'(m_busy));
    chk("valid80", 64'(valid80), 64'(m_valid));
    chk("valid128", 64'(valid128), 64'(m_valid));
    chk("last80", 64'(last80), 64'(m_valid && (m_exp == m_end)));
    chk("last128", 64'(last128), 64'(m_valid && (m_exp == m_end)));
    if (m_valid) begin
      chk("idx80", 64'(idx80), 64'(m_exp));
      chk("idx128", 64'(idx128), 64'(m_exp));
      chk("rk80", rk80, gold80[m_exp]);
      chk("rk128", rk128, gold128[m_exp]);
    end
    if (rst) begin
      m_busy = 1'b0;
      m_pre = 0;
      m_after_rst = 1'b1;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_after_rst = 1'b0;
        m_rev = rev && REV_EN;
        gen_gold(k80, k128);
        m_exp = m_rev ? NUM_RK : 1;
        m_end = m_rev ? 1 : NUM_RK;
        m_pre = m_rev ? NUM_RK - 1 : 0;
      end
    end else if (m_pre > 0) begin
      m_pre--;
    end else if (ready) begin
      if (m_exp == m_end) m_busy = 1'b0;
      else if (m_rev) m_exp--;
      else m_exp++;
    end
  end

  task automatic run_to_idle(input string nm);
    int g = 0;
    while (busy80 && g < 300) begin
      cyc();
      g++;
    end
    chk(nm, 64'(busy80), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, g, n_valid, n_last, last_idx;
    bit bp_done, ign_done;
    logic [63:0] hold_rk, last_rk;
    rst = 1'b1; start = 1'b0; rev = 1'b0; ready = 1'b1; k80 = '0; k128 = '0;
    repeat (3) cyc();
    chk("reset_busy", 64'(busy80), 64'd0);
    chk("reset_valid", 64'(valid80), 64'd0);
    chk("reset_last", 64'(last80), 64'd0);
    rst = 1'b0;
    cyc();

    // Forward, all-zero key, consumer always ready.
    start = 1'b1; cyc(); start = 1'b0;
    chk("fwd_first_valid", 64'(valid80), 64'd1);
    chk("fwd_first_idx", 64'(idx80), 64'd1);
    chk("fwd_first_rk", rk80, 64'd0);
    chk("model_pin80_rk2", gold80[2], 64'hC000000000000000);
    chk("model_pin128_rk2", gold128[2], 64'hCC00000000000000);
    n_valid = 0; n_last = 0; g = 0;
    while (busy80 && g < 200) begin
      if (valid80) n_valid++;
      if (valid80 && last80) begin
        n_last++;
        chk("fwd_last_idx", 64'(idx80), 64'd32);
      end
      if (valid80 && idx80 == 6'd2) begin
        chk("fwd80_rk2", rk80, 64'hC000000000000000);
        chk("fwd128_rk2", rk128, 64'hCC00000000000000);
      end
      cyc();
      g++;
    end
    chk("fwd_emit_cycles", 64'(n_valid), 64'd32);
    chk("fwd_last_count", 64'(n_last), 64'd1);
    chk("fwd_busy_drop", 64'(busy80), 64'd0);

    // Backpressure at index 7, ignored start at index 10, then back-to-back start.
    k80 = 80'h0123456789ABCDEF0123; k128 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    start = 1'b1; cyc(); start = 1'b0;
    bp_done = 1'b0; ign_done = 1'b0; g = 0;
    while (busy80 && g < 200) begin
      if (valid80 && idx80 == 6'd7 && !bp_done) begin
        bp_done = 1'b1;
        hold_rk = rk80;
        ready = 1'b0;
        repeat (5) begin
          cyc();
          chk("bp_idx_hold", 64'(idx80), 64'd7);
          chk("bp_rk_hold", rk80, hold_rk);
          chk("bp_valid_hold", 64'(valid80), 64'd1);
        end
        ready = 1'b1;
      end
      if (valid80 && idx80 == 6'd10 && !ign_done) begin
        ign_done = 1'b1;
        start = 1'b1;
        k80 = 80'hFFFFFFFFFFFFFFFFFFFF;
        k128 = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
      end
      cyc();
      start = 1'b0;
      g++;
    end
    chk("bp_seen", 64'(bp_done), 64'd1);
    chk("ign_seen", 64'(ign_done), 64'd1);
    k80 = 80'h89ABCDEF0123456789AB; k128 = 128'h0123456789ABCDEFFEDCBA9876543210;
    start = 1'b1; cyc(); start = 1'b0;
    chk("b2b_valid", 64'(valid80), 64'd1);
    chk("b2b_idx", 64'(idx80), 64'd1);
    chk("b2b_rk80", rk80, k80[79:16]);
    chk("b2b_rk128", rk128, k128[127:64]);
    run_to_idle("b2b_done");

    // Reset in the middle of a run, then a fresh start.
    k80 = 80'h13579BDF02468ACE1357; k128 = 128'hFFEEDDCCBBAA99887766554433221100;
    start = 1'b1; cyc(); start = 1'b0;
    g = 0;
    while (!(valid80 && idx80 == 6'd15) && g < 100) begin
      cyc();
      g++;
    end
    chk("rst_reach15", 64'(idx80), 64'd15);
    rst = 1'b1; cyc();
    chk("abort_valid", 64'(valid80), 64'd0);
    chk("abort_busy", 64'(busy80), 64'd0);
    chk("abort_idx", 64'(idx80), 64'd0);
    chk("abort_last", 64'(last80), 64'd0);
    chk("abort_rk80", rk80, 64'd0);
    chk("abort_rk128", rk128, 64'd0);
    rst = 1'b0; cyc();
    k80 = 80'h0F0F0F0F0F0F0F0F0F0F; k128 = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;
    start = 1'b1; cyc(); start = 1'b0;
    chk("fresh_valid", 64'(valid80), 64'd1);
    chk("fresh_idx", 64'(idx80), 64'd1);
    chk("fresh_rk80", rk80, k80[79:16]);
    chk("fresh_rk128", rk128, k128[127:64]);
    run_to_idle("fresh_done");

    // Reverse request (forward when the reverse mode is not built in), zero key.
    k80 = '0; k128 = '0; rev = 1'b1;
    start = 1'b1; cyc(); start = 1'b0; rev = 1'b0;
    n = 1;
    while (!valid80 && n < 100) begin
      cyc();
      n++;
    end
    chk("rev_latency", 64'(n), REV_EN ? 64'd32 : 64'd1);
    chk("rev_first_idx", 64'(idx80), REV_EN ? 64'd32 : 64'd1);
    last_idx = 0; last_rk = '1; g = 0;
    while (busy80 && g < 200) begin
      if (valid80 && last80) begin
        last_idx = int'(idx80);
        last_rk = rk80;
      end
      cyc();
      g++;
    end
    chk("rev_last_idx", 64'(last_idx), REV_EN ? 64'd1 : 64'd32);
    chk("rev_last_rk", last_rk, REV_EN ? 64'd0 : gold80[32]);

    // Reverse request with a non-zero key and an irregular consumer.
    k80 = 80'hA5A5A5A5A5A5A5A5A5A5; k128 = 128'h00112233445566778899AABBCCDDEEFF; rev = 1'b1;
    start = 1'b1; cyc(); start = 1'b0; rev = 1'b0;
    g = 0;
    while (busy80 && g < 300) begin
      ready = (g % 3 != 0);
      cyc();
      g++;
    end
    ready = 1'b1;
    chk("rev2_done", 64'(busy80), 64'd0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/present_key_stream.md
# present_key_stream

Parametrised PRESENT key-schedule engine supporting 80- and 128-bit master keys, emitting one 64-bit round key per accepted transfer over a valid/ready stream. Sits between the key register file and the PRESENT round datapath; a block-level `start` loads a new master key. An optional reverse mode precomputes the final key and streams round keys last-to-first for the decryption datapath.

## Interface
- `KEY_W`, 80: master key width; legal values 80 or 128 only.
- `NUM_RK`, 32: round keys emitted per run; legal range 2..32.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  load `key_in` and begin a run; sampled only in IDLE.
- `rev`  in  1  run direction, sampled with `start`: 0 forward, 1 reverse.
- `key_in`  in  KEY_W  master key.
- `rk`  out  64  current round key, `key_reg[KEY_W-1:KEY_W-64]`.
- `rk_idx`  out  6  round index of `rk`, 1..NUM_RK.
- `rk_last`  out  1  high while `rk_valid` and this is the final key of the run.
- `rk_valid`  out  1  `rk` and `rk_idx` are valid.
- `rk_ready`  in  1  consumer accepts `rk` when high with `rk_valid`.
- `busy`  out  1  high in any state except IDLE.

## Operation
- States: IDLE, PRE (reverse precompute), EMIT.
- Forward update f(K,i), i = 5-bit counter: K = K rotated left 61; for KEY_W=80, `K[79:76]=S(K[79:76])`, `K[19:15]^=i`; for KEY_W=128, `K[127:124]=S(K[127:124])`, `K[123:120]=S(K[123:120])`, `K[66:62]^=i`. S is the PRESENT S-box (C56B90AD3EF84712).
- Inverse update g(K,i): undo the XOR of i, apply inverse S-box to the same nibble(s), rotate right 61.
- IDLE: `start`=1 -> `key_reg<=key_in`. If forward (or reverse disabled): `rk_idx<=1`, go EMIT. If reverse: counter `c<=1`, go PRE.
- PRE: each cycle `key_reg<=f(key_reg,c)`, `c<=c+1`; after the update with c=NUM_RK-1, `rk_idx<=NUM_RK`, go EMIT.
- EMIT forward: on handshake (`rk_valid&&rk_ready`), if `rk_idx==NUM_RK` go IDLE; else `key_reg<=f(key_reg,rk_idx)`, `rk_idx<=rk_idx+1`.
- EMIT reverse: on handshake, if `rk_idx==1` go IDLE; else `key_reg<=g(key_reg,rk_idx-1)`, `rk_idx<=rk_idx-1`.
- `rk_valid` = (state==EMIT). `rk_last` = `rk_valid` and `rk_idx` equals NUM_RK (forward) or 1 (reverse).
- `start` outside IDLE is ignored; no error flag. `key_in`/`rev` are sampled only on the accepting cycle.
- Counter values are 5 bits; index 32 is never used as an XOR operand.

## Timing
- Reset: state IDLE, `key_reg`=0, `rk_idx`=0, `rk_valid`=0, `rk_last`=0, `busy`=0; `rk`=0.
- `rst` mid-run aborts immediately; the next cycle is IDLE with reset values, and no partial key is emitted.
- Forward: `start` accepted at edge T -> `rk_valid`=1 with `rk_idx`=1 after T. With `rk_ready` held high, one key per cycle; a full run takes NUM_RK cycles in EMIT.
- Reverse: first `rk_valid` after NUM_RK-1 PRE cycles, i.e. NUM_RK cycles after `start`.
- While `rk_valid`=1 and `rk_ready`=0, `rk`, `rk_idx` and `rk_last` are held stable.
- The handshake on the last key returns to IDLE. `start` in the following cycle is accepted, with no dead cycle beyond it.

## Configuration
- `PRESENT_KS_REVERSE_EN` defined: PRE state, the inverse S-box and g() are compiled in, and `rev` is honoured.
- Undefined: the `rev` port remains but is ignored, and every run is forward. PRE and the inverse logic are absent. Interface and forward timing are unchanged.

## Test plan
- KEY_W=80, key_in=0, `rk_ready`=1, forward -> rk_idx 1: `rk`=0x0000000000000000; rk_idx 2: `rk`=0xC000000000000000; `rk_last` only at rk_idx 32; `busy` drops the cycle after.
- KEY_W=128, key_in=0, forward -> rk_idx 2: `rk`=0xCC00000000000000. All 32 keys must match the golden model.
- Reverse (macro on), KEY_W=80, key_in=0 -> first `rk_valid` 32 cycles after `start`, with `rk_idx`=32 equal to forward key 32. The last key is `rk_idx`=1, `rk`=0, `rk_last`=1.
- Backpressure: drop `rk_ready` for 5 cycles at rk_idx 7 -> `rk`/`rk_idx` stable throughout, and the sequence resumes at 8 with no skip or duplicate.
- `start` pulsed at rk_idx 10 with a different key -> ignored, and the run completes with the original key. Back-to-back `start` the cycle after the final handshake -> new run begins.
- `rst` asserted at rk_idx 15 -> next cycle: all outputs at reset values. A fresh `start` then gives `rk_idx`=1 with the new key.
